sobel_stream: RTL



---
 rtl/sobel_pkg.sv | 24 ++
 rtl/sobel_line_buffer.sv | 26 ++
 rtl/sobel_stream.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - Mode/state encodings and width helper shared by the Sobel stream filter
package sobel_pkg;

  typedef enum logic [1:0] {
    MODE_GX   = 2'd0,
    MODE_GY   = 2'd1,
    MODE_MAG  = 2'd2,
    MODE_EDGE = 2'd3
  } sobel_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } sobel_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// rtl/sobel_line_buffer.sv - One-row pixel delay RAM, column addressed, read-before-write
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 1280
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic [clog2(IMG_W)-1:0] addr,
  input  logic [DATA_W-1:0]       din,
  output logic [DATA_W-1:0]       dout
);

  logic [DATA_W-1:0] mem_q [IMG_W];

  // Read is combinational so the same beat sees the pixel from one row earlier before overwriting it.
  assign dout = mem_q[addr];

  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[addr] <= din;
    end
  end

endmodule

// File: rtl/sobel_stream.sv
// rtl/sobel_stream.sv - Streaming 3x3 Sobel filter: raster counters, FSM, window and 2-stage kernel
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 1280,
  parameter int IMG_H  = 720,
  parameter int OUT_W  = DATA_W + 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       din,
  input  logic                    din_valid,
  input  logic                    sof,
  input  logic [1:0]              mode,
  input  logic [OUT_W-1:0]        thresh,
  output logic [OUT_W-1:0]        dout,
  output logic                    dout_valid,
  output logic [clog2(IMG_H)-1:0] dout_row,
  output logic [clog2(IMG_W)-1:0] dout_col,
  output logic                    dout_last,
  output logic                    frame_err,
  output logic [1:0]              state
);

  localparam int ROW_W = clog2(IMG_H);
  localparam int COL_W = clog2(IMG_W);
  localparam int GW    = DATA_W + 3;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);

  sobel_state_e      state_q;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  sobel_mode_e       mode_q;
  logic [OUT_W-1:0]  thresh_q;
  logic              frame_err_q;

  logic              active, restart, accept;
  logic [ROW_W-1:0]  cur_row;
  logic [COL_W-1:0]  cur_col;

  always_comb begin
    active  = (state_q == FILL) || (state_q == RUN);
    restart = din_valid && sof;
    accept  = restart || (din_valid && active);
    cur_row = restart ? '0 : row_q;
    cur_col = restart ? '0 : col_q;
    row_d   = row_q;
    col_d   = col_q;
    if (accept) begin
      if (cur_col == LAST_COL) begin
        col_d = '0;
        row_d = (cur_row == LAST_ROW) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      mode_q      <= MODE_GX;
      thresh_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      frame_err_q <= restart && active;
      if (restart) begin
        mode_q   <= sobel_mode_e'(mode);
        thresh_q <= thresh;
        state_q  <= FILL;
      end else if (accept) begin
        case (state_q)
          FILL:    if (cur_row == ROW_W'(1) && cur_col == LAST_COL) state_q <= RUN;
          RUN:     if (cur_row == LAST_ROW && cur_col == LAST_COL) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  logic [DATA_W-1:0] lb0_rd, lb1_rd;

  sobel_line_buffer #(.DATA_W(DATA_W), .IMG_W(IMG_W)) u_lb_row1 (
    .clk  (clk),
    .en   (accept),
    .addr (cur_col),
    .din  (din),
    .dout (lb0_rd)
  );

  sobel_line_buffer #(.DATA_W(DATA_W), .IMG_W(IMG_W)) u_lb_row2 (
    .clk  (clk),
    .en   (accept),
    .addr (cur_col),
    .din  (lb0_rd),
    .dout (lb1_rd)
  );

  // Window row 0 is the oldest line (r-2), column 2 the newest pixel (c).
  logic [DATA_W-1:0] win_q [3][3];
  logic              win_valid_q, win_last_q;
  logic [ROW_W-1:0]  win_row_q;
  logic [COL_W-1:0]  win_col_q;
  sobel_mode_e       win_mode_q;
  logic [OUT_W-1:0]  win_thresh_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < 3; i++) begin
        win_q[i][0] <= win_q[i][1];
        win_q[i][1] <= win_q[i][2];
      end
      win_q[0][2]  <= lb1_rd;
      win_q[1][2]  <= lb0_rd;
      win_q[2][2]  <= din;
      win_row_q    <= cur_row - 1'b1;
      win_col_q    <= cur_col - 1'b1;
      win_last_q   <= (cur_row == LAST_ROW) && (cur_col == LAST_COL);
      win_mode_q   <= mode_q;
      win_thresh_q <= thresh_q;
    end
  end

  function automatic logic signed [GW-1:0] tap3(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [DATA_W-1:0] c);
    return $signed(GW'(a) + GW'({b, 1'b0}) + GW'(c));
  endfunction

  logic signed [GW-1:0] gx_c, gy_c;
  always_comb begin
    gx_c = tap3(win_q[0][2], win_q[1][2], win_q[2][2]) - tap3(win_q[0][0], win_q[1][0], win_q[2][0]);
    gy_c = tap3(win_q[0][0], win_q[0][1], win_q[0][2]) - tap3(win_q[2][0], win_q[2][1], win_q[2][2]);
  end

  logic                 s1_valid_q, s1_last_q;
  logic signed [GW-1:0] s1_gx_q, s1_gy_q;
  logic [ROW_W-1:0]     s1_row_q;
  logic [COL_W-1:0]     s1_col_q;
  sobel_mode_e          s1_mode_q;
  logic [OUT_W-1:0]     s1_thresh_q;

  always_ff @(posedge clk) begin
    if (win_valid_q) begin
      s1_gx_q     <= gx_c;
      s1_gy_q     <= gy_c;
      s1_row_q    <= win_row_q;
      s1_col_q    <= win_col_q;
      s1_last_q   <= win_last_q;
      s1_mode_q   <= win_mode_q;
      s1_thresh_q <= win_thresh_q;
    end
  end

  logic [GW-1:0]    abs_gx, abs_gy;
  logic [OUT_W-1:0] mag, result;
  always_comb begin
    abs_gx = s1_gx_q[GW-1] ? $unsigned(-s1_gx_q) : $unsigned(s1_gx_q);
    abs_gy = s1_gy_q[GW-1] ? $unsigned(-s1_gy_q) : $unsigned(s1_gy_q);
    mag    = OUT_W'(abs_gx) + OUT_W'(abs_gy);
    case (s1_mode_q)
      MODE_GX:  result = {{(OUT_W-GW){s1_gx_q[GW-1]}}, s1_gx_q};
      MODE_GY:  result = {{(OUT_W-GW){s1_gy_q[GW-1]}}, s1_gy_q};
      MODE_MAG: result = mag;
      default:  result = (mag >= s1_thresh_q) ? '1 : '0;
    endcase
  end

  logic [OUT_W-1:0] dout_q;
  logic             dout_valid_q, dout_last_q;
  logic [ROW_W-1:0] dout_row_q;
  logic [COL_W-1:0] dout_col_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid_q  <= 1'b0;
      s1_valid_q   <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      dout_q       <= '0;
      dout_row_q   <= '0;
      dout_col_q   <= '0;
    end else begin
      win_valid_q  <= accept && (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
      s1_valid_q   <= win_valid_q;
      dout_valid_q <= s1_valid_q;
      dout_last_q  <= s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        dout_q     <= result;
        dout_row_q <= s1_row_q;
        dout_col_q <= s1_col_q;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_row   = dout_row_q;
  assign dout_col   = dout_col_q;
  assign dout_last  = dout_last_q;
  assign frame_err  = frame_err_q;
  assign state      = state_q;

endmodule
